// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, captures the fetched word into IF/ID, detects end of program.
// 1-cycle latency from the instruction to IF/ID; stall holds the PC and IF/ID, flush and redirect insert a bubble.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DRAIN    = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        drain_last,
    output logic        halted
);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT} state_t;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [3:0]  DRAIN_LOAD = 4'(DRAIN - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] pc_nxt, pc_plus4, target;
    logic        fetch_ev, zero_fetch, bubble, hold;
    logic        drain_last_nxt, halted_nxt;

    assign pc_plus4   = pc + 32'd4;
    assign target     = branch_target & 32'hFFFF_FFFC;
    assign fetch_ev   = (state == S_RUN) && !stall && !flush && !branch_taken;
    assign zero_fetch = fetch_ev && (instruction == 32'h0);

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        pc_nxt         = pc;
        drain_last_nxt = 1'b0;
        halted_nxt     = halted;
        bubble         = 1'b0;
        hold           = 1'b0;

        case (state)
            S_RUN: begin
                // The zero word freezes the PC on itself; the drain begins there.
                if (branch_taken)
                    pc_nxt = target;
                else if (!stall && !zero_fetch)
                    pc_nxt = pc_plus4;
                if (zero_fetch) begin
                    state_nxt = S_DRAIN;
                    cnt_nxt   = DRAIN_LOAD;
                end
            end
            S_DRAIN: begin
                if (branch_taken) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = 4'd0;
                    pc_nxt    = target;
                end else if (cnt == 4'd0) begin
                    state_nxt  = S_HALT;
                    halted_nxt = 1'b1;
                end else begin
                    cnt_nxt        = cnt - 4'd1;
                    drain_last_nxt = (cnt == 4'd1);
                end
            end
            default: begin
                state_nxt = S_HALT;
            end
        endcase

        if (branch_taken || flush)
            bubble = 1'b1;
        else if (stall)
            hold = 1'b1;
        else if (state != S_RUN || instruction == 32'h0)
            bubble = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_RUN;
            cnt         <= 4'd0;
            pc          <= RESET_PC;
            if_id_pc    <= 32'h0;
            if_id_pc4   <= 32'h0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
            drain_last  <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            pc         <= pc_nxt;
            drain_last <= drain_last_nxt;
            halted     <= halted_nxt;
            if (bubble) begin
                if_id_pc    <= 32'h0;
                if_id_pc4   <= 32'h0;
                if_id_instr <= NOP_INSTR;
                if_id_valid <= 1'b0;
            end else if (!hold) begin
                if_id_pc    <= pc;
                if_id_pc4   <= pc_plus4;
                if_id_instr <= instruction;
                if_id_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_fetch_stage;

    localparam int DRAIN = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0, flush = 1'b0, branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic [31:0] instruction;
    logic [31:0] pc, if_id_pc, if_id_pc4, if_id_instr;
    logic        if_id_valid, drain_last, halted;

    logic [31:0] imem [0:63];
    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc, m_ifpc, m_ifpc4, m_ifinstr;
    logic        m_ifv, m_draining, m_halted, m_dl;
    int          m_since;

    fetch_stage #(.RESET_PC(32'h0), .DRAIN(DRAIN)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .instruction(instruction), .pc(pc), .if_id_pc(if_id_pc),
        .if_id_pc4(if_id_pc4), .if_id_instr(if_id_instr),
        .if_id_valid(if_id_valid), .drain_last(drain_last), .halted(halted)
    );

    always #5 clk = ~clk;
    assign instruction = imem[pc[7:2]];

    task automatic fill_mem();
        for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0093 | (32'(i) << 20);
        imem[0] = 32'h0050_0093;
        imem[1] = 32'h00A0_0113;
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_ifpc = 32'h0; m_ifpc4 = 32'h0; m_ifinstr = 32'h13;
        m_ifv = 1'b0; m_draining = 1'b0; m_halted = 1'b0; m_dl = 1'b0; m_since = 0;
    endtask

    task automatic model_bubble();
        m_ifpc = 32'h0; m_ifpc4 = 32'h0; m_ifinstr = 32'h13; m_ifv = 1'b0;
    endtask

    // One rising edge of the fetch stage described by its rules, not its encoding.
    task automatic model_step(input logic s, input logic f, input logic b, input logic [31:0] t);
        logic [31:0] word;
        word = imem[m_pc[7:2]];
        m_dl = 1'b0;
        if (m_halted) begin
            // frozen until reset
        end else if (m_draining) begin
            model_bubble();
            if (b) begin
                m_draining = 1'b0;
                m_pc = {t[31:2], 2'b00};
            end else begin
                m_since++;
                if (m_since == DRAIN - 1) m_dl = 1'b1;
                if (m_since == DRAIN) begin
                    m_halted = 1'b1;
                    m_draining = 1'b0;
                end
            end
        end else if (b) begin
            m_pc = {t[31:2], 2'b00};
            model_bubble();
        end else if (s) begin
            if (f) model_bubble();
        end else if (f) begin
            m_pc = m_pc + 32'd4;
            model_bubble();
        end else if (word == 32'h0) begin
            m_draining = 1'b1;
            m_since = 0;
            model_bubble();
        end else begin
            m_ifpc = m_pc; m_ifpc4 = m_pc + 32'd4; m_ifinstr = word; m_ifv = 1'b1;
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic do_reset();
        stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({pc, if_id_pc, if_id_pc4, if_id_instr} !== {32'h0, 32'h0, 32'h0, 32'h13} ||
            {if_id_valid, drain_last, halted} !== 3'b000) begin
            errors++;
            $display("FAIL reset: pc=%h ifpc=%h ifpc4=%h instr=%h v=%b dl=%b h=%b, want 0,0,0,13,0,0,0",
                     pc, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, drain_last, halted);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_instr [0:1];
        exp_instr[0] = 32'h0050_0093;
        exp_instr[1] = 32'h00A0_0113;
        for (int k = 0; k < 2; k++) begin
            edge_step();
            checks++;
            if (pc !== 32'(4 * (k + 1)) || if_id_pc !== 32'(4 * k) || if_id_pc4 !== 32'(4 * k + 4) ||
                if_id_instr !== exp_instr[k] || if_id_valid !== 1'b1) begin
                errors++;
                $display("FAIL seq[%0d]: pc=%h ifpc=%h ifpc4=%h instr=%h v=%b, want %h,%h,%h,%h,1", k,
                         pc, if_id_pc, if_id_pc4, if_id_instr, if_id_valid,
                         32'(4 * (k + 1)), 32'(4 * k), 32'(4 * k + 4), exp_instr[k]);
            end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            edge_step();
            checks++;
            if (pc !== 32'h8 || if_id_pc !== 32'h4 || if_id_instr !== 32'h00A0_0113 || if_id_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall[%0d]: pc=%h ifpc=%h instr=%h v=%b, want 8,4,00a00113,1",
                         k, pc, if_id_pc, if_id_instr, if_id_valid);
            end
        end
        stall = 1'b0;
        edge_step();
        checks++;
        if (pc !== 32'hC || if_id_pc !== 32'h8 || if_id_pc4 !== 32'hC || if_id_instr !== imem[2]) begin
            errors++;
            $display("FAIL stall_resume: pc=%h ifpc=%h ifpc4=%h instr=%h, want c,8,c,%h",
                     pc, if_id_pc, if_id_pc4, if_id_instr, imem[2]);
        end
    endtask

    task automatic test_branch();
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0043;
        edge_step();
        checks++;
        if (pc !== 32'h40 || if_id_instr !== 32'h13 || if_id_valid !== 1'b0 || if_id_pc !== 32'h0) begin
            errors++;
            $display("FAIL branch: pc=%h instr=%h v=%b ifpc=%h, want 40,13,0,0",
                     pc, if_id_instr, if_id_valid, if_id_pc);
        end
        stall = 1'b0; branch_taken = 1'b0;
        edge_step();
        checks++;
        if (if_id_pc !== 32'h40 || if_id_valid !== 1'b1 || if_id_instr !== imem[16] || pc !== 32'h44) begin
            errors++;
            $display("FAIL branch_follow: ifpc=%h v=%b instr=%h pc=%h, want 40,1,%h,44",
                     if_id_pc, if_id_valid, if_id_instr, pc, imem[16]);
        end
    endtask

    task automatic test_drain();
        imem[4] = 32'h0;
        branch_taken = 1'b1; branch_target = 32'h10;
        edge_step();
        branch_taken = 1'b0;
        edge_step();
        checks++;
        if (pc !== 32'h10 || if_id_valid !== 1'b0 || if_id_instr !== 32'h13 || drain_last !== 1'b0) begin
            errors++;
            $display("FAIL drain_enter: pc=%h v=%b instr=%h dl=%b, want 10,0,13,0",
                     pc, if_id_valid, if_id_instr, drain_last);
        end
        for (int k = 1; k <= 8; k++) begin
            branch_taken = (k >= 6);
            branch_target = 32'h80;
            edge_step();
            checks++;
            if (drain_last !== (k == 4) || halted !== (k >= 5) || pc !== 32'h10 || if_id_valid !== 1'b0) begin
                errors++;
                $display("FAIL drain[%0d]: dl=%b h=%b pc=%h v=%b, want %b,%b,10,0",
                         k, drain_last, halted, pc, if_id_valid, k == 4, k >= 5);
            end
        end
        branch_taken = 1'b0;
    endtask

    task automatic test_drain_cancel();
        do_reset();
        branch_taken = 1'b1; branch_target = 32'h10;
        edge_step();
        branch_taken = 1'b0;
        edge_step();
        edge_step();
        branch_taken = 1'b1; branch_target = 32'h20;
        edge_step();
        branch_taken = 1'b0;
        checks++;
        if (pc !== 32'h20 || drain_last !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL cancel: pc=%h dl=%b h=%b, want 20,0,0", pc, drain_last, halted);
        end
        edge_step();
        checks++;
        if (if_id_pc !== 32'h20 || if_id_valid !== 1'b1 || if_id_instr !== imem[8] || pc !== 32'h24) begin
            errors++;
            $display("FAIL cancel_resume: ifpc=%h v=%b instr=%h pc=%h, want 20,1,%h,24",
                     if_id_pc, if_id_valid, if_id_instr, pc, imem[8]);
        end
        for (int k = 0; k < 6; k++) begin
            edge_step();
            checks++;
            if (drain_last !== 1'b0 || halted !== 1'b0) begin
                errors++;
                $display("FAIL cancel_quiet[%0d]: dl=%b h=%b, want 0,0", k, drain_last, halted);
            end
        end
    endtask

    task automatic test_async_reset();
        branch_taken = 1'b1; branch_target = 32'h10;
        edge_step();
        branch_taken = 1'b0;
        edge_step();
        edge_step();
        edge_step();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({pc, if_id_pc, if_id_pc4, if_id_instr} !== {32'h0, 32'h0, 32'h0, 32'h13} ||
            {if_id_valid, drain_last, halted} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset: pc=%h ifpc=%h ifpc4=%h instr=%h v=%b dl=%b h=%b, want 0,0,0,13,0,0,0",
                     pc, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, drain_last, halted);
        end
        @(negedge clk);
        reset = 1'b0;
        edge_step();
        checks++;
        if (pc !== 32'h4 || if_id_instr !== 32'h0050_0093 || if_id_valid !== 1'b1) begin
            errors++;
            $display("FAIL restart: pc=%h instr=%h v=%b, want 4,00500093,1", pc, if_id_instr, if_id_valid);
        end
    endtask

    task automatic test_wrap();
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
        edge_step();
        branch_taken = 1'b0;
        checks++;
        if (pc !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_target: pc=%h, want fffffffc", pc);
        end
        edge_step();
        checks++;
        if (pc !== 32'h0 || if_id_pc !== 32'hFFFF_FFFC || if_id_pc4 !== 32'h0 || if_id_instr !== imem[63]) begin
            errors++;
            $display("FAIL wrap: pc=%h ifpc=%h ifpc4=%h instr=%h, want 0,fffffffc,0,%h",
                     pc, if_id_pc, if_id_pc4, if_id_instr, imem[63]);
        end
    endtask

    task automatic test_random();
        logic s, f, b;
        logic [31:0] t;
        int halt_age = 0;
        for (int i = 0; i < 64; i++)
            imem[i] = ($urandom_range(0, 15) == 0) ? 32'h0 : ($urandom | 32'h1);
        imem[0] = 32'h0050_0093;
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (m_halted) halt_age++;
            if (halt_age > 3 || $urandom_range(0, 199) == 0) begin
                do_reset();
                halt_age = 0;
            end
            s = ($urandom_range(0, 4) == 0);
            f = ($urandom_range(0, 9) == 0);
            b = ($urandom_range(0, 9) == 0);
            t = $urandom;
            stall = s; flush = f; branch_taken = b; branch_target = t;
            model_step(s, f, b, t);
            edge_step();
            checks++;
            if (pc !== m_pc || if_id_pc !== m_ifpc || if_id_pc4 !== m_ifpc4 || if_id_instr !== m_ifinstr ||
                if_id_valid !== m_ifv || drain_last !== m_dl || halted !== m_halted) begin
                errors++;
                $display("FAIL random[%0d]: got pc=%h ifpc=%h ifpc4=%h instr=%h v=%b dl=%b h=%b want %h %h %h %h %b %b %b",
                         cyc, pc, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, drain_last, halted,
                         m_pc, m_ifpc, m_ifpc4, m_ifinstr, m_ifv, m_dl, m_halted);
            end
        end
        stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
    endtask

    initial begin
        fill_mem();
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_drain();
        test_drain_cancel();
        test_async_reset();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage RISC-V pipeline. Owns the program counter, drives the address into the instruction memory, captures the returned word into the IF/ID pipeline register, and applies stall, flush and branch-redirect requests from the hazard unit and EX stage. It also detects end of program: an all-zero fetched word starts a fixed pipeline-drain countdown that ends in a sticky halt.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- DRAIN, 5, cycles between fetching the zero word and asserting halted; legal range 2..15
- clk  in  1  pipeline clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- stall  in  1  hold PC and IF/ID (load-use hazard)
- flush  in  1  replace the IF/ID contents with a bubble
- branch_taken  in  1  redirect request from EX
- branch_target  in  32  redirect address; bits [1:0] ignored and forced to 0
- instruction  in  32  word returned by the instruction memory for pc in the same cycle (combinational)
- pc  out  32  current fetch address to the instruction memory
- if_id_pc  out  32  PC of the instruction in IF/ID
- if_id_pc4  out  32  if_id_pc + 4
- if_id_instr  out  32  instruction in IF/ID
- if_id_valid  out  1  IF/ID holds a real instruction
- drain_last  out  1  high for exactly the one cycle before halted rises
- halted  out  1  sticky end-of-program flag

## Operation
- States: RUN, DRAIN, HALT. Reset enters RUN.
- A fetch event is a RUN-state cycle with stall=0, flush=0 and branch_taken=0.
- Next-PC priority, highest first:
  - HALT: hold.
  - branch_taken: {branch_target[31:2],2'b00}.
  - stall: hold.
  - DRAIN: hold.
  - Otherwise: pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- IF/ID priority, highest first:
  - branch_taken or flush: bubble.
  - stall: hold.
  - DRAIN or HALT: bubble.
  - Fetch event with instruction==0: bubble, and the state goes to DRAIN.
  - Otherwise: capture pc, pc+4, instruction, valid=1.
- Bubble contents: if_id_instr=32'h0000_0013 (addi x0,x0,0), if_id_pc=0, if_id_pc4=0, if_id_valid=0.
- The zero word is never forwarded downstream.
- Drain counter (4 bits):
  - Loaded with DRAIN-1 on the RUN→DRAIN transition.
  - Decrements every DRAIN cycle; stall does not pause it.
  - drain_last=1 while in DRAIN with counter==1.
  - At counter==0 in DRAIN, the state goes to HALT.
- branch_taken while in DRAIN cancels the drain: the state returns to RUN, the counter is cleared and the PC is redirected. The zero word was on a wrong path.
- HALT ignores stall, flush and branch_taken and holds until reset.
- stall and flush together: flush wins for IF/ID, and the PC holds.

## Timing
- Reset values: pc=RESET_PC, if_id_pc=0, if_id_pc4=0, if_id_instr=32'h0000_0013, if_id_valid=0, drain_last=0, halted=0, state=RUN, counter=0.
- pc is registered. instruction is sampled combinationally in the same cycle, and the IF/ID outputs reflect it after the next rising edge, giving 1-cycle latency.
- Redirect: branch_taken sampled at edge N gives pc=target after edge N, with a bubble in IF/ID. The first target instruction reaches IF/ID after edge N+1.
- Zero word fetched at edge N: DRAIN after N. drain_last is high for the cycle after edge N+DRAIN-1 and low again after edge N+DRAIN. halted rises after edge N+DRAIN.
- With DRAIN=5: zero at edge N gives drain_last during N+4..N+5 and halted from N+5.
- drain_last and halted are registered outputs, glitch-free.
- Asserting reset mid-DRAIN or in HALT returns every output to its reset value asynchronously. Fetch restarts at RESET_PC on the first edge after reset is released.

## Test plan
- Reset release with RESET_PC=0 and memory words 0x00500093, 0x00A00113 → pc steps 0,4,8. if_id_instr gets 0x00500093 and then 0x00A00113 with if_id_pc 0,4 and if_id_pc4 4,8, and if_id_valid=1.
- stall for 2 cycles while pc=8 → pc stays 8 and IF/ID holds the pc=4 entry for 2 cycles. Fetch then resumes at 8 with no skipped or duplicated instruction.
- branch_taken with branch_target=0x00000043 together with stall → pc=0x40 next cycle and IF/ID holds a bubble (0x00000013, valid=0). if_id_pc=0x40 follows one cycle later.
- Zero word at pc=0x10 with DRAIN=5 → pc frozen at 0x10 and IF/ID bubbles. drain_last is high for exactly one cycle, 4 edges after the fetch, and halted rises 5 edges after it and stays high under later branch_taken pulses.
- Zero word fetched, then branch_taken to 0x20 two cycles into DRAIN → no drain_last or halted. State returns to RUN and fetch resumes at 0x20.
- Assert reset asynchronously mid-cycle in DRAIN → all outputs go to their reset values before the next edge. Start pc=32'hFFFFFFFC with no stall → next pc=0.
